// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce block.
// Holds the per-channel FSM state encoding and the helpers that size the counters.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_e;

    // A counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle between the raw push-buttons and the digit-entry stage.
//   btn_raw   : raw active-high buttons, asynchronous to clk
//   btn_level : debounced level, 1 while a button is accepted as held
//   btn_press : one-cycle pulse per accepted press (and per repeat)
// master = button source / observer side, slave = debouncer.
interface button_debounce_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;

    modport master (output btn_raw, input btn_level, input btn_press);
    modport slave  (input btn_raw, output btn_level, output btn_press);
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, stable-time FSM, counters and
// registered level/press outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_raw      : raw button input
//   o_level    : debounced level
//   o_press    : one-cycle press pulse
// Optional auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY_CYC = 50_000_000,
    parameter int REPEAT_RATE_CYC  = 10_000_000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_s1, r_s2;
    btn_state_e    r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_level, w_level_nx;
    logic          r_press, w_press_nx;

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RW         = cnt_w(max2(REPEAT_DELAY_CYC, REPEAT_RATE_CYC));
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

    logic [RW-1:0] r_rcnt, w_rcnt_nx;
    logic          r_rep, w_rep_nx;   // first repeat already issued in this hold
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rcnt  <= '0;
            r_rep   <= 1'b0;
`endif
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_level <= w_level_nx;
            r_press <= w_press_nx;
`ifdef BTN_AUTOREPEAT_EN
            r_rcnt  <= w_rcnt_nx;
            r_rep   <= w_rep_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_level_nx = r_level;
        w_press_nx = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rcnt_nx  = r_rcnt;
        w_rep_nx   = r_rep;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_s2) begin
                    w_state_nx = ST_PRESS_CHK;
                    w_cnt_nx   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!r_s2) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_HELD;
                    w_cnt_nx   = '0;
                    w_level_nx = 1'b1;
                    w_press_nx = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    w_rcnt_nx  = '0;
                    w_rep_nx   = 1'b0;
`endif
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            ST_HELD: begin
                if (!r_s2) begin
                    w_state_nx = ST_RELEASE_CHK;
                    w_cnt_nx   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                // First period uses the delay, later ones the rate.
                else if (r_rcnt == (r_rep ? RATE_LAST : DELAY_LAST)) begin
                    w_press_nx = 1'b1;
                    w_rcnt_nx  = '0;
                    w_rep_nx   = 1'b1;
                end else begin
                    w_rcnt_nx = r_rcnt + RW'(1);
                end
`endif
            end
            ST_RELEASE_CHK: begin
                // Repeat counter is left untouched here so a bounced release
                // resumes the repeat schedule where it stopped.
                if (r_s2) begin
                    w_state_nx = ST_HELD;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_level_nx = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/button_debounce.sv
// Debounces the up/down/left/right push-buttons ahead of the digit-entry
// stage; one independent channel per button.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : button_debounce_if.slave (btn_raw in, btn_level/btn_press out)
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat pulses.
module button_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY_CYC = 50_000_000,
    parameter int REPEAT_RATE_CYC  = 10_000_000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    button_debounce_if.slave   bus
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
`endif
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (bus.btn_raw[i]),
            .o_level (w_level[i]),
            .o_press (w_press[i])
        );
    end

    assign bus.btn_level = w_level;
    assign bus.btn_press = w_press;

endmodule
